zeroskip_tile_sched: RTL and testbench
======================================

Name: zeroskip_tile_sched

Overview:
- Tile-level scheduler in front of the 256-MAC zero-skip datapath.
- Joins the upstream activation and znz-mask streams and issues paired beats into the datapath only when a downstream credit is free.
- Latches the sparsity mode (8:16 or 8:32) per tile, counts input beats and encoded outputs, and raises done when a tile has fully drained.
- The datapath has no backpressure, so this block owns all flow control.

Parameters:
- M, 16, datapath row count; each beat carries 2*M act bytes and 2*M masks of M bits.
- DATA_W, 8, activation width.
- LEN_W, 16, width of tile length counters.
- CREDIT_MAX, 4, downstream output-buffer slots.
- CREDIT_W, $clog2(CREDIT_MAX+1), credit counter width.

Ports:
- clk  in  1  single clock; one clock domain, all logic on posedge clk.
- a_rst  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  one-cycle start pulse; accepted only in IDLE.
- cfg_nz_sel  in  1  0 = 8:32 (quarter, two beats per output), 1 = 8:16 (half, one beat per output); latched at start.
- cfg_tile_len  in  LEN_W  number of encoded outputs in the tile.
- cfg_abort  in  1  abort the current tile.
- act_vld_i / act_rdy_o  in/out  1  upstream activation handshake.
- act_i  in  2*M*DATA_W  activation beat.
- znz_vld_i / znz_rdy_o  in/out  1  upstream mask handshake.
- znz_i  in  2*M*M  mask beat.
- zs_enable_o  out  1  datapath enable.
- zs_nz_sel_o  out  1  latched mode to the datapath.
- zs_act_o / zs_act_vld_o  out  2*M*DATA_W / 1  registered activation beat to the datapath.
- zs_znz_o / zs_znz_vld_o  out  2*M*M / 1  registered mask beat to the datapath.
- zs_enc_vld_i  in  1  datapath output-valid pulse.
- crd_ret_i  in  1  downstream frees one slot.
- busy_o  out  1  high when state is not IDLE.
- done_o  out  1  one-cycle pulse at tile end.
- err_o  out  2  sticky error flags: [0] credit overflow, [1] stray enc_vld.

Behaviour:
Reset values:
- State IDLE; all vld/rdy outputs 0; data registers 0; zs_enable_o 0; zs_nz_sel_o 0; credits = CREDIT_MAX; counters 0; err_o 0.

States IDLE -> RUN -> DRAIN -> DONE -> IDLE:
- IDLE:
  - cfg_start latches mode and len, and sets beats_total = len (half) or 2*len (quarter).
  - If len == 0, go to DONE; otherwise go to RUN.
- RUN:
  - A beat fires when act_vld_i & znz_vld_i & credit_ok & beats_issued < beats_total.
  - Both rdy outputs equal that condition minus the vld terms. They are always equal, so the two streams are consumed together.
  - credit_ok = credits > 0. In quarter mode credit_ok is checked only on even beats; odd beats are always ok because the slot is already reserved.
  - Credit decrement: every beat in half mode; even beats only in quarter mode.
  - Fired beat is registered to zs_*_o with zs_*_vld_o = 1 for exactly one cycle. Latency from input handshake to zs_*_vld_o is 1 cycle.
  - When the last beat fires, go to DRAIN.
- DRAIN: count zs_enc_vld_i; when outs_seen == len, go to DONE.
- DONE: done_o = 1 for one cycle, then return to IDLE.
- zs_enable_o = 1 in RUN and DRAIN.
- outs_seen counts zs_enc_vld_i in RUN and DRAIN.

Credits:
- crd_ret_i and a decrement in the same cycle leave credits unchanged.
- A return at CREDIT_MAX saturates the counter and sets err_o[0].

Boundary conditions:
- cfg_start outside IDLE is ignored, with no side effects.
- zs_enc_vld_i in IDLE or DONE sets err_o[1] and is not counted.
- cfg_abort in RUN or DRAIN:
  - go to IDLE next cycle; rdy outputs drop immediately (combinational);
  - clear counters; no done_o;
  - credits are not restored (downstream returns them).
- cfg_abort in IDLE has no effect.
- Quarter-mode abort after an odd number of beats leaves the half-pair in the datapath; a subsequent start must be preceded by datapath reset (system rule).
- a_rst mid-tile returns everything to reset values asynchronously. err_o clears only on a_rst.
- Counter widths: beats counter LEN_W+1 bits so 2*len cannot overflow.

Decomposition:
- Package zeroskip_pkg holds:
  - sched_state_t enum {IDLE, RUN, DRAIN, DONE};
  - nz_mode_t enum {NZ_QUAR=0, NZ_HALF=1};
  - err bit index constants.
- One sub-module, zs_credit_ctr:
  - inputs: take, give;
  - outputs: avail, overflow flag;
  - parameter CREDIT_MAX.

Test Plan:
1. Half mode, len=3, streams always valid, crd_ret every cycle -> 3 beats on consecutive cycles, zs_act_vld_o 1 cycle after each handshake; done_o after the 3rd enc_vld.
2. Quarter mode, len=2, CREDIT_MAX=1, no crd_ret -> beats 0,1 fire, beat 2 stalls (rdy=0); crd_ret pulse -> beats 2,3 fire; 4 beats total.
3. Half mode, len=4, CREDIT_MAX=2, no returns -> exactly 2 beats issue, rdy stays 0; credits 0.
4. len=0 start -> busy_o high 1 cycle, done_o pulse, no beats issued.
5. Abort in quarter mode after 3 of 8 beats -> IDLE next cycle, no done_o; cfg_start during RUN ignored; stray enc_vld in IDLE sets err_o=2'b10.
6. crd_ret with credits=CREDIT_MAX -> err_o[0]=1, credits stay 4; a_rst asserted mid-RUN -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/zeroskip_pkg.sv
// Shared types for the zero-skip tile scheduler: FSM states, sparsity
// mode encoding and bit positions inside the sticky error vector.
package zeroskip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Encoding matches cfg_nz_sel so the input can be cast directly.
    typedef enum logic {
        NZ_QUAR = 1'b0,
        NZ_HALF = 1'b1
    } nz_mode_t;

    localparam int ERR_W         = 2;
    localparam int ERR_CRD_OVF   = 0;
    localparam int ERR_STRAY_ENC = 1;

endpackage

// File: rtl/zs_credit_ctr.sv
// Downstream output-buffer credit counter. Starts full, take consumes a
// slot, give returns one. A simultaneous take and give cancel out; a give
// while already full saturates and raises a one-cycle overflow pulse.
module zs_credit_ctr #(
    parameter int CREDIT_MAX = 4,
    parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
    input  logic clk,
    input  logic a_rst,
    input  logic take,
    input  logic give,
    output logic avail,
    output logic overflow
);

    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDIT_MAX);

    logic [CREDIT_W-1:0] credits;

    assign avail    = (credits != '0);
    assign overflow = give && !take && (credits == FULL);

    // Credit count update; take never arrives at zero because the scheduler gates it with avail.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            credits <= FULL;
        end else if (take && !give) begin
            if (credits != '0) begin
                credits <= credits - 1'b1;
            end
        end else if (give && !take) begin
            if (credits != FULL) begin
                credits <= credits + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zeroskip_tile_sched.sv
// Tile scheduler in front of the 256-MAC zero-skip datapath. Joins the
// activation and mask streams, issues paired beats only when a downstream
// credit is available, tracks beats and encoded outputs per tile and
// signals done once the tile has drained. The datapath has no backpressure,
// so every flow-control decision is made here.
module zeroskip_tile_sched
    import zeroskip_pkg::*;
#(
    parameter int M          = 16,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 16,
    parameter int CREDIT_MAX = 4,
    parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    a_rst,
    input  logic                    cfg_start,
    input  logic                    cfg_nz_sel,
    input  logic [LEN_W-1:0]        cfg_tile_len,
    input  logic                    cfg_abort,
    input  logic                    act_vld_i,
    output logic                    act_rdy_o,
    input  logic [2*M*DATA_W-1:0]   act_i,
    input  logic                    znz_vld_i,
    output logic                    znz_rdy_o,
    input  logic [2*M*M-1:0]        znz_i,
    output logic                    zs_enable_o,
    output logic                    zs_nz_sel_o,
    output logic [2*M*DATA_W-1:0]   zs_act_o,
    output logic                    zs_act_vld_o,
    output logic [2*M*M-1:0]        zs_znz_o,
    output logic                    zs_znz_vld_o,
    input  logic                    zs_enc_vld_i,
    input  logic                    crd_ret_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ERR_W-1:0]        err_o
);

    sched_state_t     state;
    nz_mode_t         mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] outs_seen;
    logic [LEN_W:0]   beats_total;
    logic [LEN_W:0]   beats_issued;

    logic credit_avail;
    logic credit_ovf;
    logic credit_ok;
    logic issue_ok;
    logic fire;
    logic take;
    logic last_beat;
    logic stray_enc;

    // Issue qualification: odd quarter-mode beats ride on the slot reserved by the even beat before them.
    always_comb begin
        credit_ok = credit_avail;
        if (mode_q == NZ_QUAR && beats_issued[0]) begin
            credit_ok = 1'b1;
        end
        issue_ok  = (state == RUN) && !cfg_abort && credit_ok && (beats_issued < beats_total);
        fire      = issue_ok && act_vld_i && znz_vld_i;
        take      = fire && (mode_q == NZ_HALF || !beats_issued[0]);
        last_beat = ((beats_issued + 1'b1) == beats_total);
        stray_enc = zs_enc_vld_i && (state == IDLE || state == DONE);
    end

    assign act_rdy_o = issue_ok;
    assign znz_rdy_o = issue_ok;

    zs_credit_ctr #(
        .CREDIT_MAX (CREDIT_MAX),
        .CREDIT_W   (CREDIT_W)
    ) u_credit (
        .clk      (clk),
        .a_rst    (a_rst),
        .take     (take),
        .give     (crd_ret_i),
        .avail    (credit_avail),
        .overflow (credit_ovf)
    );

    // Tile FSM with registered busy/enable/done and the per-tile counters.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state        <= IDLE;
            mode_q       <= NZ_QUAR;
            len_q        <= '0;
            beats_total  <= '0;
            beats_issued <= '0;
            outs_seen    <= '0;
            zs_nz_sel_o  <= 1'b0;
            zs_enable_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        mode_q       <= nz_mode_t'(cfg_nz_sel);
                        zs_nz_sel_o  <= cfg_nz_sel;
                        len_q        <= cfg_tile_len;
                        beats_total  <= cfg_nz_sel ? {1'b0, cfg_tile_len} : {cfg_tile_len, 1'b0};
                        beats_issued <= '0;
                        outs_seen    <= '0;
                        busy_o       <= 1'b1;
                        if (cfg_tile_len == '0) begin
                            state       <= DONE;
                            done_o      <= 1'b1;
                            zs_enable_o <= 1'b0;
                        end else begin
                            state       <= RUN;
                            zs_enable_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cfg_abort) begin
                        state        <= IDLE;
                        beats_total  <= '0;
                        beats_issued <= '0;
                        outs_seen    <= '0;
                        zs_enable_o  <= 1'b0;
                        busy_o       <= 1'b0;
                    end else begin
                        if (fire) begin
                            beats_issued <= beats_issued + 1'b1;
                            if (last_beat) begin
                                state <= DRAIN;
                            end
                        end
                        if (zs_enc_vld_i) begin
                            outs_seen <= outs_seen + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cfg_abort) begin
                        state        <= IDLE;
                        beats_total  <= '0;
                        beats_issued <= '0;
                        outs_seen    <= '0;
                        zs_enable_o  <= 1'b0;
                        busy_o       <= 1'b0;
                    end else if (outs_seen == len_q) begin
                        state       <= DONE;
                        zs_enable_o <= 1'b0;
                        done_o      <= 1'b1;
                    end else if (zs_enc_vld_i) begin
                        outs_seen <= outs_seen + 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    beats_total  <= '0;
                    beats_issued <= '0;
                    outs_seen    <= '0;
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            err_o <= '0;
        end else begin
            if (credit_ovf) begin
                err_o[ERR_CRD_OVF] <= 1'b1;
            end
            if (stray_enc) begin
                err_o[ERR_STRAY_ENC] <= 1'b1;
            end
        end
    end

    // Register each fired beat toward the datapath; valid lasts exactly one cycle.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            zs_act_o     <= '0;
            zs_znz_o     <= '0;
            zs_act_vld_o <= 1'b0;
            zs_znz_vld_o <= 1'b0;
        end else begin
            zs_act_vld_o <= fire;
            zs_znz_vld_o <= fire;
            if (fire) begin
                zs_act_o <= act_i;
                zs_znz_o <= znz_i;
            end
        end
    end

endmodule

// File: tb/tb_zeroskip_tile_sched.sv
// Directed bench for the zero-skip tile scheduler: half/quarter tiles,
// credit stalls, zero-length tiles, abort, error flags and async reset.
module tb_zeroskip_tile_sched;

    localparam int M      = 16;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;
    localparam int ACT_W  = 2*M*DATA_W;
    localparam int ZNZ_W  = 2*M*M;

    logic               clk = 1'b0;
    logic               a_rst;
    logic               cfg_start;
    logic               cfg_nz_sel;
    logic [LEN_W-1:0]   cfg_tile_len;
    logic               cfg_abort;
    logic               act_vld_i;
    logic               act_rdy_o;
    logic [ACT_W-1:0]   act_i;
    logic               znz_vld_i;
    logic               znz_rdy_o;
    logic [ZNZ_W-1:0]   znz_i;
    logic               zs_enable_o;
    logic               zs_nz_sel_o;
    logic [ACT_W-1:0]   zs_act_o;
    logic               zs_act_vld_o;
    logic [ZNZ_W-1:0]   zs_znz_o;
    logic               zs_znz_vld_o;
    logic               zs_enc_vld_i;
    logic               crd_ret_i;
    logic               busy_o;
    logic               done_o;
    logic [1:0]         err_o;

    logic [31:0] tag;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          beats;

    zeroskip_tile_sched #(
        .M          (M),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .CREDIT_MAX (4)
    ) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .cfg_start    (cfg_start),
        .cfg_nz_sel   (cfg_nz_sel),
        .cfg_tile_len (cfg_tile_len),
        .cfg_abort    (cfg_abort),
        .act_vld_i    (act_vld_i),
        .act_rdy_o    (act_rdy_o),
        .act_i        (act_i),
        .znz_vld_i    (znz_vld_i),
        .znz_rdy_o    (znz_rdy_o),
        .znz_i        (znz_i),
        .zs_enable_o  (zs_enable_o),
        .zs_nz_sel_o  (zs_nz_sel_o),
        .zs_act_o     (zs_act_o),
        .zs_act_vld_o (zs_act_vld_o),
        .zs_znz_o     (zs_znz_o),
        .zs_znz_vld_o (zs_znz_vld_o),
        .zs_enc_vld_i (zs_enc_vld_i),
        .crd_ret_i    (crd_ret_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic vld, input logic [31:0] t);
        tag       = t;
        act_vld_i = vld;
        znz_vld_i = vld;
        act_i     = {8{t}};
        znz_i     = {16{~t}};
    endtask

    task automatic start_tile(input logic sel, input logic [LEN_W-1:0] len);
        cfg_start    = 1'b1;
        cfg_nz_sel   = sel;
        cfg_tile_len = len;
        tick();
        cfg_start    = 1'b0;
    endtask

    task automatic count_beats(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(act_vld_i, tag + 32'd1);
            tick();
            if (zs_act_vld_o) cnt++;
        end
    endtask

    task automatic return_credits(input int n);
        for (int i = 0; i < n; i++) begin
            crd_ret_i = 1'b1;
            tick();
            crd_ret_i = 1'b0;
        end
    endtask

    task automatic pulse_enc(input int n);
        for (int i = 0; i < n; i++) begin
            zs_enc_vld_i = 1'b1;
            tick();
            zs_enc_vld_i = 1'b0;
        end
    endtask

    initial begin
        a_rst        = 1'b1;
        cfg_start    = 1'b0;
        cfg_nz_sel   = 1'b0;
        cfg_tile_len = '0;
        cfg_abort    = 1'b0;
        zs_enc_vld_i = 1'b0;
        crd_ret_i    = 1'b0;
        apply_stimulus(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;

        // Reset state
        check_output("rst_busy",   512'(busy_o),       512'(0));
        check_output("rst_done",   512'(done_o),       512'(0));
        check_output("rst_rdy",    512'(act_rdy_o),    512'(0));
        check_output("rst_zsvld",  512'(zs_act_vld_o), 512'(0));
        check_output("rst_enable", 512'(zs_enable_o),  512'(0));
        check_output("rst_err",    512'(err_o),        512'(0));

        // Half mode, len=3, returns alongside each beat
        apply_stimulus(1'b1, 32'hA0);
        start_tile(1'b1, 16'd3);
        check_output("t1_busy",   512'(busy_o),      512'(1));
        check_output("t1_enable", 512'(zs_enable_o), 512'(1));
        check_output("t1_nzsel",  512'(zs_nz_sel_o), 512'(1));
        check_output("t1_rdy",    512'(znz_rdy_o),   512'(1));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'hA0 + 32'(i));
            crd_ret_i = 1'b1;
            tick();
            check_output("t1_beat_vld", 512'(zs_znz_vld_o), 512'(1));
            check_output("t1_beat_act", 512'(zs_act_o), 512'({8{32'hA0 + 32'(i)}}));
            check_output("t1_beat_znz", 512'(zs_znz_o), 512'({16{~(32'hA0 + 32'(i))}}));
        end
        crd_ret_i = 1'b0;
        apply_stimulus(1'b0, 32'h0);
        check_output("t1_drain_rdy",  512'(act_rdy_o),   512'(0));
        check_output("t1_drain_busy", 512'(busy_o),      512'(1));
        pulse_enc(3);
        check_output("t1_not_done_yet", 512'(done_o), 512'(0));
        tick();
        check_output("t1_done",        512'(done_o),      512'(1));
        check_output("t1_done_enable", 512'(zs_enable_o), 512'(0));
        tick();
        check_output("t1_done_pulse", 512'(done_o), 512'(0));
        check_output("t1_idle_busy",  512'(busy_o), 512'(0));

        // Half mode, len=6, no returns: only the four credits' worth issue
        apply_stimulus(1'b1, 32'hB0);
        start_tile(1'b1, 16'd6);
        count_beats(8, beats);
        check_output("t3_beats",     512'(beats),     512'(4));
        check_output("t3_stall_rdy", 512'(act_rdy_o), 512'(0));
        return_credits(1);
        check_output("t3_ret_rdy", 512'(act_rdy_o), 512'(1));
        count_beats(4, beats);
        check_output("t3_beats_after_ret", 512'(beats), 512'(1));
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check_output("t3_abort_busy", 512'(busy_o), 512'(0));
        check_output("t3_abort_done", 512'(done_o), 512'(0));
        apply_stimulus(1'b0, 32'h0);
        return_credits(4);
        check_output("t3_err_clean", 512'(err_o), 512'(0));

        // Quarter mode, len=5 (10 beats): even beats need a credit
        apply_stimulus(1'b1, 32'hC0);
        start_tile(1'b0, 16'd5);
        check_output("t2_nzsel", 512'(zs_nz_sel_o), 512'(0));
        count_beats(12, beats);
        check_output("t2_beats",     512'(beats),     512'(8));
        check_output("t2_stall_rdy", 512'(act_rdy_o), 512'(0));
        return_credits(1);
        check_output("t2_ret_rdy", 512'(act_rdy_o), 512'(1));
        count_beats(4, beats);
        check_output("t2_pair_beats", 512'(beats),     512'(2));
        check_output("t2_drain_rdy",  512'(act_rdy_o), 512'(0));
        apply_stimulus(1'b0, 32'h0);
        pulse_enc(5);
        tick();
        check_output("t2_done", 512'(done_o), 512'(1));
        tick();
        check_output("t2_idle_busy", 512'(busy_o), 512'(0));
        return_credits(4);

        // Zero-length tile
        apply_stimulus(1'b1, 32'hD0);
        start_tile(1'b1, 16'd0);
        check_output("t4_busy",   512'(busy_o),       512'(1));
        check_output("t4_done",   512'(done_o),       512'(1));
        check_output("t4_enable", 512'(zs_enable_o),  512'(0));
        check_output("t4_rdy",    512'(act_rdy_o),    512'(0));
        tick();
        check_output("t4_busy_after", 512'(busy_o),       512'(0));
        check_output("t4_no_beat",    512'(zs_act_vld_o), 512'(0));

        // Quarter abort after 3 of 8 beats, ignored restart, stray enc_vld
        apply_stimulus(1'b1, 32'hE0);
        start_tile(1'b0, 16'd4);
        count_beats(3, beats);
        check_output("t5_beats", 512'(beats), 512'(3));
        apply_stimulus(1'b0, 32'h0);
        start_tile(1'b1, 16'd1);
        check_output("t5_restart_nzsel", 512'(zs_nz_sel_o), 512'(0));
        check_output("t5_restart_busy",  512'(busy_o),      512'(1));
        check_output("t5_odd_rdy",       512'(act_rdy_o),   512'(1));
        cfg_abort = 1'b1;
        #1;
        check_output("t5_abort_act_rdy", 512'(act_rdy_o), 512'(0));
        check_output("t5_abort_znz_rdy", 512'(znz_rdy_o), 512'(0));
        tick();
        cfg_abort = 1'b0;
        check_output("t5_abort_busy",   512'(busy_o),      512'(0));
        check_output("t5_abort_done",   512'(done_o),      512'(0));
        check_output("t5_abort_enable", 512'(zs_enable_o), 512'(0));
        pulse_enc(1);
        check_output("t5_stray_err", 512'(err_o), 512'(2'b10));
        return_credits(2);
        check_output("t5_err_kept", 512'(err_o), 512'(2'b10));

        // Return at full credits saturates, then async reset mid-tile
        return_credits(1);
        check_output("t6_ovf_err", 512'(err_o), 512'(2'b11));
        apply_stimulus(1'b1, 32'hF0);
        start_tile(1'b1, 16'd6);
        count_beats(8, beats);
        check_output("t6_sat_beats", 512'(beats), 512'(4));
        a_rst = 1'b1;
        #1;
        check_output("t6_rst_busy",   512'(busy_o),      512'(0));
        check_output("t6_rst_rdy",    512'(act_rdy_o),   512'(0));
        check_output("t6_rst_enable", 512'(zs_enable_o), 512'(0));
        check_output("t6_rst_nzsel",  512'(zs_nz_sel_o), 512'(0));
        check_output("t6_rst_err",    512'(err_o),       512'(0));
        check_output("t6_rst_act",    512'(zs_act_o),    512'(0));
        check_output("t6_rst_znz",    512'(zs_znz_o),    512'(0));
        a_rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
